// File: rtl/inv_mix_add_key_serial.sv
// AES-128 decrypt-round AddRoundKey followed by InvMixColumns, computed one
// 32-bit column per cycle with valid/ready handshakes on input and output.
module inv_mix_add_key_serial #(
  parameter int unsigned NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int unsigned CW = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [127:0]    st;
  logic            last;
  logic [6:0]      base;
  logic [31:0]     col_in;
  logic [31:0]     col_res;
  logic [7:0]      a  [4];
  logic [7:0]      a2 [4];
  logic [7:0]      a4 [4];
  logic [7:0]      a8 [4];
  logic [7:0]      b  [4];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column 0 occupies the top 32 bits, so the bit offset is (3-col)*32.
  assign base   = {~col, 5'b00000};
  assign col_in = st[base +: 32];

  // 0e = x8^x4^x2, 0b = x8^x2^x1, 0d = x8^x4^x1, 09 = x8^x1
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r]  = col_in[31-8*r -: 8];
      a2[r] = xt(a[r]);
      a4[r] = xt(a2[r]);
      a8[r] = xt(a4[r]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      b[r] = (a8[r] ^ a4[r] ^ a2[r])
           ^ (a8[(r+1)%4] ^ a2[(r+1)%4] ^ a[(r+1)%4])
           ^ (a8[(r+2)%4] ^ a4[(r+2)%4] ^ a[(r+2)%4])
           ^ (a8[(r+3)%4] ^ a[(r+3)%4]);
    end
    col_res = last ? col_in : {b[0], b[1], b[2], b[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      st        <= '0;
      last      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= state_in ^ round_key;
            last     <= last_round;
            col      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          data_out[base +: 32] <= col_res;
          col                  <= col + 1'b1;
          if (col == CW'(NUM_COLS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_add_key_serial.sv
// Directed and randomized checks of inv_mix_add_key_serial against a
// generic GF(2^8) multiply reference model.
module tb_inv_mix_add_key_serial;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_mix_add_key_serial #(.NUM_COLS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .round_key  (round_key),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = x;
    logic [7:0] bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic l);
    logic [127:0] x = s ^ k;
    logic [127:0] y;
    logic [7:0]   av [4];
    if (l) return x;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) av[r] = x[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        y[127-32*c-8*r -: 8] = gmul(8'h0e, av[r]) ^ gmul(8'h0b, av[(r+1)%4])
                             ^ gmul(8'h0d, av[(r+2)%4]) ^ gmul(8'h09, av[(r+3)%4]);
    end
    return y;
  endfunction

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V3_KEY = {16{8'h0f}};
  localparam logic [127:0] V3_OUT = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  // Present a block at a negedge and hold it until accepted; returns at the
  // negedge following the accepting edge with in_valid dropped.
  task automatic drive_accept(input logic [127:0] s, input logic [127:0] k, input logic l,
                              output bit timeout);
    int n = 0;
    @(negedge clk);
    state_in = s; round_key = k; last_round = l; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    timeout = !in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = ~s; round_key = ~k; last_round = ~l;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    state_in = '0; round_key = '0; last_round = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_block(input string name, input logic [127:0] s, input logic [127:0] k,
                            input logic l, input logic [127:0] exp);
    bit to;
    int lat;
    drive_accept(s, k, l, to);
    checks++; if (to) begin errors++; $display("FAIL %s_accept got timeout want accept", name); end
    wait_out(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL %s_data got %h want %h", name, data_out, exp); end
    pop_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int lat;
    logic [127:0] hold;
    drive_accept(V1_IN, '0, 1'b0, to);
    wait_out(lat);
    checks++; if (data_out !== V1_OUT) begin errors++; $display("FAIL bp_data got %h want %h", data_out, V1_OUT); end
    hold = data_out;
    for (int i = 0; i < 10; i++) begin
      in_valid  = (i % 2 == 0);
      state_in  = {4{$urandom}};
      round_key = {4{$urandom}};
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || data_out !== hold || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got ov=%b ir=%b d=%h want ov=1 ir=0 d=%h",
                 i, out_valid, in_ready, data_out, hold);
      end
    end
    in_valid = 1'b0;
    pop_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    test_block("bp_next", V3_IN, V3_KEY, 1'b1, V3_OUT);
  endtask

  task automatic test_reset_mid();
    bit to;
    drive_accept(V1_IN, '0, 1'b0, to);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got ov=%b ir=%b d=%h want ov=0 ir=1 d=0", out_valid, in_ready, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_block("after_rst", {128{1'b1}} ^ V1_IN, {128{1'b1}}, 1'b0, V1_OUT);
  endtask

  task automatic test_random();
    logic [127:0] expq[$];
    int received = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [127:0] s, k;
          logic l;
          int guard = 0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          s = {$urandom, $urandom, $urandom, $urandom};
          k = {$urandom, $urandom, $urandom, $urandom};
          l = ($urandom_range(0, 3) == 0);
          state_in = s; round_key = k; last_round = l; in_valid = 1'b1;
          while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          if (!in_ready) begin
            checks++; errors++;
            $display("FAIL rnd_accept blk %0d got timeout want accept", i);
          end
          expq.push_back(model(s, k, l));
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        int cyc = 0;
        while (received < 100 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 1) == 1);
          if (out_valid && out_ready) begin
            logic [127:0] exp;
            exp = (expq.size() > 0) ? expq.pop_front() : 'x;
            checks++;
            if (data_out !== exp) begin
              errors++;
              $display("FAIL rnd_data blk %0d got %h want %h", received, data_out, exp);
            end
            received++;
          end
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (received != 100) begin
      errors++;
      $display("FAIL rnd_count got %0d want 100", received);
    end
  endtask

  initial begin
    test_reset();
    test_block("vec1", V1_IN, '0, 1'b0, V1_OUT);
    test_block("vec2", ~V1_IN, {128{1'b1}}, 1'b0, V1_OUT);
    test_block("vec3", V3_IN, V3_KEY, 1'b1, V3_OUT);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
